// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB slave hosting a 32-bit down-counting timer.
//
// Features: 8-bit prescaler, one-shot or auto-reload mode, and a level
// interrupt. Writes complete with zero wait states. Reads insert one wait
// state; during that cycle the read data is captured into a register.
//
// Register map (word offsets; paddr[1:0] ignored; hit only when
// paddr[ADDR_WIDTH-1:5] == 0):
//   0x00 CTRL     RW  [0] EN, [1] IRQ_EN, [2] RELOAD
//   0x04 LOAD     RW
//   0x08 VALUE    RO  (a write here is an error)
//   0x0C PRESCALE RW  [7:0]
//   0x10 INTSTAT  W1C [0]
//
// Ports:
//   hclk, hreset_n          clock, asynchronous active-low reset
//   psel, penable, paddr,   APB request from the bridge
//   pwrite, pwdata
//   prdata, pready, pslverr APB response (pslverr valid only with pready)
//   timer_irq               level interrupt, INTSTAT & IRQ_EN delayed 1 cycle
module apb_timer_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  timer_irq
);

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DONE = 1'b1
  } rd_state_e;

  rd_state_e             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] load_q, load_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [7:0]            prescale_q, prescale_d;
  logic [7:0]            pcnt_q, pcnt_d;
  logic                  intstat_q, intstat_d;
  logic                  irq_q, irq_d;

  logic [2:0]            word_s;
  logic                  addr_hit_s;
  logic                  map_rd_s;
  logic                  map_wr_s;
  logic                  access_s;
  logic                  wr_ok_s;
  logic                  rd_s;
  logic                  tick_s;
  logic                  suppress_s;
  logic                  expire_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  unused_s;

  assign unused_s   = ^paddr[1:0];
  assign word_s     = paddr[4:2];
  assign addr_hit_s = (paddr[ADDR_WIDTH-1:5] == {(ADDR_WIDTH-5){1'b0}});
  assign map_rd_s   = addr_hit_s && (word_s <= 3'd4);
  assign map_wr_s   = map_rd_s && (word_s != 3'd2);
  assign access_s   = psel & penable;
  assign wr_ok_s    = access_s & pwrite & map_wr_s;
  assign rd_s       = access_s & ~pwrite;

  // A tick fires on the cycle the prescale counter has reached PRESCALE.
  assign tick_s     = ctrl_q[0] && (pcnt_q == prescale_q);
  // A LOAD write, or a CTRL write that stops the timer, overrides a tick.
  assign suppress_s = wr_ok_s && ((word_s == 3'd1) || ((word_s == 3'd0) && !pwdata[0]));

  // Writes are answered immediately; reads only once the data is registered.
  assign pready    = access_s & (pwrite | (rd_state_q == RD_DONE));
  assign pslverr   = pready & (pwrite ? ~map_wr_s : ~map_rd_s);
  assign prdata    = prdata_q;
  assign timer_irq = irq_q;

  // Read data multiplexer for the addressed register.
  always_comb begin
    rdata_s = {DATA_WIDTH{1'b0}};
    case (word_s)
      3'd0:    rdata_s = {{(DATA_WIDTH-3){1'b0}}, ctrl_q};
      3'd1:    rdata_s = load_q;
      3'd2:    rdata_s = value_q;
      3'd3:    rdata_s = {{(DATA_WIDTH-8){1'b0}}, prescale_q};
      3'd4:    rdata_s = {{(DATA_WIDTH-1){1'b0}}, intstat_q};
      default: rdata_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Read wait-state FSM: capture data in RD_IDLE, present it in RD_DONE.
  always_comb begin
    rd_state_d = rd_state_q;
    prdata_d   = prdata_q;
    if (!psel) begin
      rd_state_d = RD_IDLE;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (rd_s) begin
            rd_state_d = RD_DONE;
            prdata_d   = map_rd_s ? rdata_s : {DATA_WIDTH{1'b0}};
          end else begin
            rd_state_d = RD_IDLE;
          end
        end
        RD_DONE: rd_state_d = RD_IDLE;
        default: rd_state_d = RD_IDLE;
      endcase
    end
  end

  // Timer datapath: prescaler, countdown, expiry, then register writes,
  // which take priority over the countdown; expiry beats a W1C of INTSTAT.
  always_comb begin
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    value_d    = value_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    intstat_d  = intstat_q;
    expire_s   = 1'b0;

    if (ctrl_q[0]) begin
      pcnt_d = tick_s ? 8'd0 : (pcnt_q + 8'd1);
    end else begin
      pcnt_d = pcnt_q;
    end

    if (tick_s && !suppress_s) begin
      if (value_q != {DATA_WIDTH{1'b0}}) begin
        value_d = value_q - {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        expire_s = 1'b1;
        if (ctrl_q[2]) begin
          value_d = load_q;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end
    end else begin
      expire_s = 1'b0;
    end

    if (wr_ok_s) begin
      case (word_s)
        3'd0: begin
          ctrl_d = pwdata[2:0];
          if (!ctrl_q[0] && pwdata[0]) begin
            pcnt_d = 8'd0;
          end else begin
            pcnt_d = pcnt_d;
          end
        end
        3'd1: begin
          load_d  = pwdata;
          value_d = pwdata;
          pcnt_d  = 8'd0;
        end
        3'd3: prescale_d = pwdata[7:0];
        3'd4: begin
          if (pwdata[0]) begin
            intstat_d = 1'b0;
          end else begin
            intstat_d = intstat_q;
          end
        end
        default: intstat_d = intstat_d;
      endcase
    end else begin
      ctrl_d = ctrl_d;
    end

    if (expire_s) begin
      intstat_d = 1'b1;
    end else begin
      intstat_d = intstat_d;
    end
  end

  // Interrupt output is registered from the current status and enable.
  always_comb begin
    irq_d = intstat_q & ctrl_q[1];
  end

  // State registers.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      rd_state_q <= RD_IDLE;
      prdata_q   <= {DATA_WIDTH{1'b0}};
      ctrl_q     <= 3'd0;
      load_q     <= {DATA_WIDTH{1'b0}};
      value_q    <= {DATA_WIDTH{1'b0}};
      prescale_q <= 8'd0;
      pcnt_q     <= 8'd0;
      intstat_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      prdata_q   <= prdata_d;
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      value_q    <= value_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      intstat_q  <= intstat_d;
      irq_q      <= irq_d;
    end
  end

endmodule
